// File: rtl/fir_fold_pkg.sv
// Shared constants and types for the folded 5-tap FIR front end.
package fir_fold_pkg;
  localparam int FOLD   = 5;
  localparam int DATA_W = 9;
  localparam int COEF_W = 13;
  localparam int ACC_W  = 22;
  localparam int TAP_W  = $clog2(FOLD);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_e;
  typedef logic [TAP_W-1:0] tap_t;
endpackage

// File: rtl/fold_sample_mem.sv
// Sample storage, DEPTH x DATA_W, one write port and one synchronous read port.
// Read data appears one cycle after rd_en_i and holds until the next read.
module fold_sample_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 9
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_dat_o
);
  logic [DATA_W-1:0] array [DEPTH];
  logic [DATA_W-1:0] rd_dat_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) array[wr_addr_i] <= wr_dat_i;
    if (rd_en_i) rd_dat_q <= array[rd_addr_i];
  end

  assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/fold_sample_sequencer.sv
// Feeds FOLD tap beats per sample to the folded MAC; first beat 2 cycles after start, outputs hold while out_ready is low.
// SEQ_FULL_WINDOW_EN: prime FOLD-1 samples first so only full windows (n >= FOLD-1) are issued.
module fold_sample_sequencer
  import fir_fold_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] x_out,
  output logic [TAP_W-1:0]  tap_sel,
  output logic              first_tap,
  output logic              last_tap,
  output logic [ADDR_W-1:0] sample_idx,
  output logic              busy,
  output logic              done
);
`ifdef SEQ_FULL_WINDOW_EN
  localparam tap_t LOAD_LAST = tap_t'(FOLD - 1);
`else
  localparam tap_t LOAD_LAST = tap_t'(0);
`endif
  localparam tap_t              TAP_LAST = tap_t'(FOLD - 1);
  localparam logic [ADDR_W-1:0] N_LAST   = ADDR_W'(DEPTH - 1);

  seq_state_e        state_q, state_d;
  tap_t              tap_q, tap_d;
  tap_t              ld_cnt_q, ld_cnt_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] dly_q [FOLD];
  logic [DATA_W-1:0] dly_d [FOLD];
  logic [DATA_W-1:0] pf_q, pf_d;
  logic              pf_pend_q, pf_pend_d;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_dat;
  logic              run;

  fold_sample_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sample_mem (
    .clk_i    (clk100),
    .wr_en_i  (1'b0),
    .wr_addr_i('0),
    .wr_dat_i ('0),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_dat_o (rd_dat)
  );

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    ld_cnt_d  = ld_cnt_q;
    n_d       = n_q;
    dly_d     = dly_q;
    pf_d      = pf_q;
    pf_pend_d = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    if (pf_pend_q) pf_d = rd_dat;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Address 0 is read here so its data lands during LOAD.
          state_d  = LOAD;
          rd_en    = 1'b1;
          tap_d    = '0;
          ld_cnt_d = '0;
          n_d      = ADDR_W'(LOAD_LAST);
          for (int k = 0; k < FOLD; k++) dly_d[k] = '0;
        end
      end
      LOAD: begin
        for (int k = FOLD - 1; k > 0; k--) dly_d[k] = dly_q[k-1];
        dly_d[0] = rd_dat;
        if (ld_cnt_q == LOAD_LAST) begin
          state_d = RUN;
        end else begin
          ld_cnt_d = ld_cnt_q + tap_t'(1);
          rd_en    = 1'b1;
          rd_addr  = ADDR_W'(ld_cnt_q) + ADDR_W'(1);
        end
      end
      RUN: begin
        if (tap_q == '0 && n_q != N_LAST) begin
          rd_en     = 1'b1;
          rd_addr   = n_q + ADDR_W'(1);
          pf_pend_d = 1'b1;
        end
        if (out_ready) begin
          if (tap_q == TAP_LAST) begin
            tap_d = '0;
            if (n_q == N_LAST) begin
              state_d = DONE;
            end else begin
              n_d = n_q + ADDR_W'(1);
              for (int k = FOLD - 1; k > 0; k--) dly_d[k] = dly_q[k-1];
              dly_d[0] = pf_q;
            end
          end else begin
            tap_d = tap_q + tap_t'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      ld_cnt_q  <= '0;
      n_q       <= '0;
      pf_q      <= '0;
      pf_pend_q <= 1'b0;
      for (int k = 0; k < FOLD; k++) dly_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      ld_cnt_q  <= ld_cnt_d;
      n_q       <= n_d;
      pf_q      <= pf_d;
      pf_pend_q <= pf_pend_d;
      dly_q     <= dly_d;
    end
  end

  assign run        = (state_q == RUN);
  assign out_valid  = run;
  assign x_out      = run ? dly_q[tap_q] : '0;
  assign tap_sel    = run ? tap_q : '0;
  assign first_tap  = run && (tap_q == '0);
  assign last_tap   = run && (tap_q == TAP_LAST);
  assign sample_idx = run ? n_q : '0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
endmodule

// File: tb/tb_fold_sample_sequencer.sv
// Randomised bench for fold_sample_sequencer against a window-level reference model.
module tb_fold_sample_sequencer;
  localparam int DEPTH = 256;
  localparam int FOLD  = 5;
`ifdef SEQ_FULL_WINDOW_EN
  localparam int N0 = FOLD - 1;
`else
  localparam int N0 = 0;
`endif
  localparam int NBEATS = (DEPTH - N0) * FOLD;

  logic       clk100 = 1'b0;
  logic       reset, start, out_ready;
  logic       out_valid, first_tap, last_tap, busy, done;
  logic [8:0] x_out;
  logic [2:0] tap_sel;
  logic [7:0] sample_idx;

  fold_sample_sequencer dut (
    .clk100    (clk100),
    .reset     (reset),
    .start     (start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .x_out     (x_out),
    .tap_sel   (tap_sel),
    .first_tap (first_tap),
    .last_tap  (last_tap),
    .sample_idx(sample_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk100 = ~clk100;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [8:0]  mem_m [DEPTH];
  logic [31:0] exp_q [$];
  int          beats, done_cnt, done_cyc, first_cyc, rd0_cnt, nstall;
  int          rdy_mode = 0;
  int          stall_cnt;
  bit          stall_done;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_vec, cur_vec;

  always @(posedge clk100) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_vec(logic v, logic f, logic l, logic [7:0] idx,
                                         logic [2:0] tap, logic [8:0] x);
    return {9'b0, v, f, l, idx, tap, x};
  endfunction

  // Every window n issues taps k=0..FOLD-1 carrying x[n-k], zero before the first sample.
  task automatic build_expected();
    logic [8:0] x;
    logic [7:0] nn;
    logic [2:0] kk;
    exp_q.delete();
    for (int n = N0; n < DEPTH; n++) begin
      for (int k = 0; k < FOLD; k++) begin
        x  = (n - k >= 0) ? mem_m[n-k] : 9'd0;
        nn = n[7:0];
        kk = k[2:0];
        exp_q.push_back(mk_vec(1'b1, k == 0, k == FOLD - 1, nn, kk, x));
      end
    end
  endtask

  task automatic load_mem(input int kind);
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        0:       mem_m[i] = (i == 0) ? 9'h001 : 9'h000;
        1:       mem_m[i] = i[8:0];
        default: mem_m[i] = 9'($urandom_range(0, 511));
      endcase
      dut.u_sample_mem.array[i] = mem_m[i];
    end
  endtask

  task automatic clear_counts();
    beats = 0; done_cnt = 0; done_cyc = -1; first_cyc = -1;
    rd0_cnt = 0; nstall = 0; stall_cnt = 0; stall_done = 1'b0;
  endtask

  // Ready driver: 0 always ready, 1 random, 2 three-cycle stall on window 10 tap 2.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk100);
      #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && sample_idx == 8'd10 && tap_sel == 3'd2 && !stall_done) begin
            stall_cnt++;
            out_ready = 1'b0;
            if (stall_cnt == 3) stall_done = 1'b1;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk100) begin
    cur_vec = mk_vec(out_valid, first_tap, last_tap, sample_idx, tap_sel, x_out);
    if (prev_stall) chk("hold", cur_vec, prev_vec);
    prev_stall = out_valid && !out_ready;
    prev_vec   = cur_vec;
    if (out_valid && first_cyc < 0) first_cyc = cyc;
    if (out_valid && !out_ready) nstall++;
    if (out_valid && out_ready) begin
      beats++;
      if (exp_q.size() > 0) chk("beat", cur_vec, exp_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dut.u_sample_mem.rd_en_i && dut.u_sample_mem.rd_addr_i == 8'd0) rd0_cnt++;
  end

  task automatic do_run(input int mode, input bit poke);
    int t;
    bit got;
    build_expected();
    clear_counts();
    rdy_mode = mode;
    got = 1'b0;
    @(posedge clk100); #1;
    start = 1'b1;
    t = cyc;
    @(posedge clk100); #1;
    start = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk100); #1;
      if (done_cnt > 0) begin
        got   = 1'b1;
        start = 1'b0;
        break;
      end
      if (poke) start = busy && ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    repeat (3) @(posedge clk100);
    #1;
    chk("done_seen", done_cnt, 1);
    chk("run_finished", got, 1);
    chk("beat_cnt", beats, NBEATS);
    chk("beats_left", exp_q.size(), 0);
    chk("rd_addr0", rd0_cnt, 1);
    chk("idle_after", {busy, out_valid}, 2'b00);
    chk("first_beat_cyc", first_cyc, t + 2 + N0);
    if (mode == 0) chk("done_cyc", done_cyc, t + 2 + N0 + NBEATS);
    if (mode == 2) chk("stall_len", nstall, 3);
    rdy_mode = 0;
  endtask

  task automatic midrun_reset();
    bit found;
    build_expected();
    clear_counts();
    rdy_mode = 0;
    found = 1'b0;
    @(posedge clk100); #1;
    start = 1'b1;
    @(posedge clk100); #1;
    start = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk100); #1;
      if (out_valid && sample_idx == 8'd100) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_found", found, 1);
    reset = 1'b1;
    @(posedge clk100); #1;
    reset = 1'b0;
    chk("mid_rst_state", {out_valid, busy, done}, 3'b000);
    exp_q.delete();
    @(posedge clk100); #1;
    chk("mid_rst_idle", {out_valid, busy}, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    clear_counts();
    @(posedge clk100);
    repeat (4) begin
      @(negedge clk100);
      chk("rst_outs", mk_vec(out_valid, first_tap, last_tap, sample_idx, tap_sel, x_out)
                      | {busy, done, 30'b0}, 32'h0);
    end
    @(posedge clk100); #1;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk100);
    #1;
    chk("idle_no_beats", beats + done_cnt, 0);
    chk("idle_busy", busy, 0);

    load_mem(0);
    do_run(0, 1'b0);

    load_mem(1);
    do_run(2, 1'b0);

    load_mem(2);
    midrun_reset();
    do_run(0, 1'b0);

    load_mem(2);
    do_run(1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
